// File: rtl/sdram_aref.sv
`default_nettype none
// ============================================================================
// Module   : sdram_aref
// Function : SDRAM periodic auto-refresh engine (PRECHARGE-all, tRP,
//            AUTO REFRESH, tRFC) with arbiter request/grant handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_aref #(
   parameter int REF_INTERVAL = 1287,
   parameter int TRP_CYC      = 3,
   parameter int TRFC_CYC     = 12
) (
   input  logic        sclk,
   input  logic        srst,
   input  logic        init_done,
   output logic        aref_req,
   input  logic        aref_en,
   output logic        aref_end,
   output logic        aref_cs_n,
   output logic        aref_ras_n,
   output logic        aref_cas_n,
   output logic        aref_we_n,
   output logic [10:0] aref_addr,
   output logic [1:0]  aref_ba,
   output logic        aref_overrun
);

   localparam int c_s_idle = 0;
   localparam int c_s_pre  = 1;
   localparam int c_s_trp  = 2;
   localparam int c_s_aref = 3;
   localparam int c_s_trfc = 4;
   localparam int c_s_end  = 5;

   localparam logic [5:0] c_st_idle = 6'b000001;
   localparam logic [5:0] c_st_pre  = 6'b000010;
   localparam logic [5:0] c_st_trp  = 6'b000100;
   localparam logic [5:0] c_st_aref = 6'b001000;
   localparam logic [5:0] c_st_trfc = 6'b010000;
   localparam logic [5:0] c_st_end  = 6'b100000;

   localparam logic [15:0] c_ref_last  = 16'(REF_INTERVAL - 1);
   // Wait states last CYC-1 cycles, so the counter runs CYC-2 down to 0.
   localparam logic [4:0]  c_trp_load  = 5'(TRP_CYC - 2);
   localparam logic [4:0]  c_trfc_load = 5'(TRFC_CYC - 2);

   logic [5:0]  r_state;
   logic [5:0]  w_state_nxt;
   logic [4:0]  r_dly;
   logic [15:0] r_int_cnt;
   logic        r_init_seen;
   logic        r_aref_req;
   logic        r_overrun;
   logic        w_wrap;
   logic        w_grant;
   logic        w_dly_zero;
   logic [3:0]  w_cmd;
   logic [10:0] w_addr;

   assign w_wrap     = r_init_seen && (r_int_cnt == c_ref_last);
   assign w_grant    = r_state[c_s_idle] && r_aref_req && aref_en;
   assign w_dly_zero = (r_dly == 5'd0);

   // Interval timer runs free so refreshes are spaced start-to-start.
   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         r_init_seen <= 1'b0;
         r_int_cnt   <= 16'd0;
         r_aref_req  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (init_done)
            r_init_seen <= 1'b1;
         if (r_init_seen)
            r_int_cnt <= w_wrap ? 16'd0 : r_int_cnt + 16'd1;
         if (w_wrap) begin
            r_aref_req <= 1'b1;
            if (r_aref_req && !w_grant)
               r_overrun <= 1'b1;
         end else if (w_grant) begin
            r_aref_req <= 1'b0;
         end
      end
   end

   always_ff @(posedge sclk or posedge srst) begin
      if (srst) begin
         r_state <= c_st_idle;
         r_dly   <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state[c_s_pre])
            r_dly <= c_trp_load;
         else if (r_state[c_s_aref])
            r_dly <= c_trfc_load;
         else if ((r_state[c_s_trp] || r_state[c_s_trfc]) && !w_dly_zero)
            r_dly <= r_dly - 5'd1;
      end
   end

   always_comb begin
      w_state_nxt = c_st_idle;
      if (r_state[c_s_idle])
         w_state_nxt = w_grant ? c_st_pre : c_st_idle;
      else if (r_state[c_s_pre])
         w_state_nxt = c_st_trp;
      else if (r_state[c_s_trp])
         w_state_nxt = w_dly_zero ? c_st_aref : c_st_trp;
      else if (r_state[c_s_aref])
         w_state_nxt = c_st_trfc;
      else if (r_state[c_s_trfc])
         w_state_nxt = w_dly_zero ? c_st_end : c_st_trfc;
      else if (r_state[c_s_end])
         w_state_nxt = c_st_idle;
   end

   always_comb begin
      w_cmd  = 4'b0111;
      w_addr = 11'd0;
      if (r_state[c_s_pre]) begin
         w_cmd  = 4'b0010;
         w_addr = 11'h400;
      end else if (r_state[c_s_aref]) begin
         w_cmd  = 4'b0001;
      end
   end

   assign {aref_cs_n, aref_ras_n, aref_cas_n, aref_we_n} = w_cmd;
   assign aref_addr    = w_addr;
   assign aref_end     = r_state[c_s_end];
   assign aref_req     = r_aref_req;
   assign aref_overrun = r_overrun;
   assign aref_ba      = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_sdram_aref.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_aref
// Function : Self-checking bench for sdram_aref against a cycle-offset model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_aref;
   localparam int RI   = 20;
   localparam int TRP  = 3;
   localparam int TRFC = 12;

   logic        sclk = 1'b0;
   logic        srst = 1'b0;
   logic        init_done = 1'b0;
   logic        aref_en = 1'b0;
   logic        aref_req, aref_end, aref_overrun;
   logic        cs_n, ras_n, cas_n, we_n;
   logic [10:0] aref_addr;
   logic [1:0]  aref_ba;

   int total = 0;
   int bad   = 0;

   sdram_aref #(.REF_INTERVAL(RI), .TRP_CYC(TRP), .TRFC_CYC(TRFC)) dut (
      .sclk(sclk), .srst(srst), .init_done(init_done),
      .aref_req(aref_req), .aref_en(aref_en), .aref_end(aref_end),
      .aref_cs_n(cs_n), .aref_ras_n(ras_n), .aref_cas_n(cas_n), .aref_we_n(we_n),
      .aref_addr(aref_addr), .aref_ba(aref_ba), .aref_overrun(aref_overrun)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: cycle index now (one per posedge), s = first cycle with init seen,
   // g = cycle holding PRECHARGE of the current/last refresh (-1 = none).
   int now = 0;
   int s   = 0;
   int g   = -1;
   bit seen = 1'b0, mreq = 1'b0, movr = 1'b0;

   function automatic bit m_busy();
      return (g >= 0) && (now <= g + TRP + TRFC);
   endfunction

   always @(posedge sclk) begin
      bit grant, wrap;
      if (srst) begin
         seen = 1'b0; g = -1; mreq = 1'b0; movr = 1'b0;
         now++;
      end else begin
         grant = !m_busy() && mreq && aref_en;
         wrap  = seen && (((now + 1 - s) % RI) == 0);
         if (wrap) begin
            if (mreq && !grant) movr = 1'b1;
            mreq = 1'b1;
         end else if (grant) begin
            mreq = 1'b0;
         end
         if (!seen && init_done) begin
            seen = 1'b1;
            s    = now + 1;
         end
         now++;
         if (grant) g = now;
      end
   end

   always @(negedge sclk) begin
      logic [3:0]  ec;
      logic [10:0] ea;
      logic        ee;
      ec = 4'b0111; ea = 11'd0; ee = 1'b0;
      if (m_busy()) begin
         if (now - g == 0) begin
            ec = 4'b0010; ea = 11'h400;
         end else if (now - g == TRP) begin
            ec = 4'b0001;
         end else if (now - g == TRP + TRFC) begin
            ee = 1'b1;
         end
      end
      chk("req",  32'(aref_req), 32'(mreq));
      chk("ovr",  32'(aref_overrun), 32'(movr));
      chk("end",  32'(aref_end), 32'(ee));
      chk("cmd",  32'({cs_n, ras_n, cas_n, we_n}), 32'(ec));
      chk("addr", 32'(aref_addr), 32'(ea));
      chk("ba",   32'(aref_ba), 32'd0);
   end

   initial begin
      int pre_cnt, aref_cnt;
      bit found;
      #1 srst = 1'b1;
      repeat (3) @(negedge sclk);
      chk("rst_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
      chk("rst_req", 32'(aref_req), 32'd0);
      srst = 1'b0;
      // No init: no activity for 200 cycles, grant pulses ignored
      for (int i = 0; i < 200; i++) begin
         aref_en = (i % 37 == 5);
         @(negedge sclk);
      end
      aref_en = 1'b0;
      chk("idle_req", 32'(aref_req), 32'd0);

      // Interval: init_done sampled at edge producing cycle 0
      init_done = 1'b1;
      @(negedge sclk);
      init_done = 1'b0;
      repeat (10) @(negedge sclk);
      aref_en = 1'b1;
      @(negedge sclk);
      aref_en = 1'b0;
      repeat (8) @(negedge sclk);
      chk("req_c19", 32'(aref_req), 32'd0);
      @(negedge sclk);
      chk("req_c20", 32'(aref_req), 32'd1);
      repeat (19) @(negedge sclk);
      chk("ovr_c39", 32'(aref_overrun), 32'd0);
      @(negedge sclk);
      chk("ovr_c40", 32'(aref_overrun), 32'd1);
      chk("req_c40", 32'(aref_req), 32'd1);

      // Sequence: grant on next edge, PRE in the following cycle
      aref_en = 1'b1;
      @(negedge sclk);
      aref_en = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         chk("seq_cmd", 32'({cs_n, ras_n, cas_n, we_n}),
             (i == 0) ? 32'h2 : (i == 3) ? 32'h1 : 32'h7);
         chk("seq_end", 32'(aref_end), (i == 15) ? 32'd1 : 32'd0);
         if (i == 0) begin
            chk("seq_addr", 32'(aref_addr), 32'h400);
            chk("seq_req", 32'(aref_req), 32'd0);
         end
         @(negedge sclk);
      end

      // Simultaneous wrap and grant, then grant held high throughout
      srst = 1'b1;
      @(negedge sclk);
      srst = 1'b0;
      init_done = 1'b1;
      @(negedge sclk);
      init_done = 1'b0;
      repeat (39) @(negedge sclk);
      aref_en = 1'b1;
      @(negedge sclk);
      chk("sim_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h2);
      chk("sim_req", 32'(aref_req), 32'd1);
      chk("sim_ovr", 32'(aref_overrun), 32'd0);
      pre_cnt = 0; aref_cnt = 0;
      for (int i = 41; i <= 72; i++) begin
         @(negedge sclk);
         if ({cs_n, ras_n, cas_n, we_n} == 4'b0010) pre_cnt++;
         if ({cs_n, ras_n, cas_n, we_n} == 4'b0001) aref_cnt++;
      end
      chk("abuse_pre", 32'(pre_cnt), 32'd1);
      chk("abuse_aref", 32'(aref_cnt), 32'd2);
      aref_en = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         srst      = ($urandom_range(0, 299) == 0);
         init_done = ($urandom_range(0, 15) == 0);
         aref_en   = ($urandom_range(0, 99) < (((i / 200) % 2 == 1) ? 10 : 60));
         @(negedge sclk);
      end
      srst = 1'b0; init_done = 1'b0; aref_en = 1'b0;

      // Reset in the AREF cycle
      init_done = 1'b1;
      aref_en   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge sclk);
         if (m_busy() && (now - g == TRP)) found = 1'b1;
      end
      chk("aref_found", 32'(found), 32'd1);
      #2 srst = 1'b1;
      #1;
      chk("mid_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
      chk("mid_end", 32'(aref_end), 32'd0);
      chk("mid_req", 32'(aref_req), 32'd0);
      init_done = 1'b0;
      aref_en   = 1'b0;
      repeat (2) @(negedge sclk);
      srst = 1'b0;
      repeat (40) @(negedge sclk);
      chk("post_req", 32'(aref_req), 32'd0);
      init_done = 1'b1;
      @(negedge sclk);
      init_done = 1'b0;
      repeat (19) @(negedge sclk);
      chk("post_c19", 32'(aref_req), 32'd0);
      @(negedge sclk);
      chk("post_c20", 32'(aref_req), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
